// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS retire-trace buffer: state encoding,
// entry layout and entry width. Define MIPS_TRACE_TIMESTAMP_EN to append a
// 32-bit cycle stamp to every entry.
package mips_trace_pkg;

    localparam logic [1:0] TR_IDLE = 2'd0;
    localparam logic [1:0] TR_PRE  = 2'd1;
    localparam logic [1:0] TR_POST = 2'd2;
    localparam logic [1:0] TR_DONE = 2'd3;

`ifdef MIPS_TRACE_TIMESTAMP_EN
    localparam int STAMP_W = 32;
`else
    localparam int STAMP_W = 0;
`endif

    // Entry layout, LSB first: [stamp], mem_wd, mem_addr, mem_we, rf_wd,
    // rf_wa, rf_we, instr, pc, then one spare bit that always reads as 0.
    function automatic int off_mem_wd(input int xlen);
        return STAMP_W;
    endfunction

    function automatic int off_mem_addr(input int xlen);
        return STAMP_W + xlen;
    endfunction

    function automatic int off_mem_we(input int xlen);
        return STAMP_W + 2 * xlen;
    endfunction

    function automatic int off_rf_wd(input int xlen);
        return STAMP_W + 2 * xlen + 1;
    endfunction

    function automatic int off_rf_wa(input int xlen);
        return STAMP_W + 3 * xlen + 1;
    endfunction

    function automatic int off_rf_we(input int xlen);
        return STAMP_W + 3 * xlen + 6;
    endfunction

    function automatic int off_instr(input int xlen);
        return STAMP_W + 3 * xlen + 7;
    endfunction

    function automatic int off_pc(input int xlen);
        return STAMP_W + 4 * xlen + 7;
    endfunction

    function automatic int entry_w(input int xlen);
        return 5 * xlen + 8 + STAMP_W;
    endfunction

endpackage

// File: rtl/mips_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module mips_trace_ram
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 168,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: entry storage is never reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read port: one-cycle registered read.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_trace_buffer.sv
// Retire-trace capture for the single-cycle MIPS core. Records one entry per
// retired instruction into a circular buffer, stops POST_TRIG entries after
// a trigger, then serves oldest-first readout. Define
// MIPS_TRACE_TIMESTAMP_EN to append a free-running cycle stamp to entries.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH     = 64,
    parameter  int POST_TRIG = 16,
    parameter  int XLEN      = 32,
    localparam int AW        = $clog2(DEPTH),
    localparam int ENTRY_W   = entry_w(XLEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               trig_ext,
    input  logic               trig_pc_en,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic               trig_mw_en,
    input  logic               tr_valid,
    input  logic [XLEN-1:0]    tr_pc,
    input  logic [XLEN-1:0]    tr_instr,
    input  logic               tr_rf_we,
    input  logic [4:0]         tr_rf_wa,
    input  logic [XLEN-1:0]    tr_rf_wd,
    input  logic               tr_mem_we,
    input  logic [XLEN-1:0]    tr_mem_addr,
    input  logic [XLEN-1:0]    tr_mem_wd,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_idx,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [1:0]         state,
    output logic [AW:0]        count,
    output logic [AW-1:0]      trig_pos,
    output logic               done
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW:0]        count_q, count_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW-1:0]      trig_pos_q, trig_pos_d;
    logic [AW:0]        trig_calc;
    logic               rd_valid_q, rd_ok_q;
    logic               hit, store, rd_hit, rd_in_range;
    logic [AW-1:0]      rd_base, rd_addr;
    logic [ENTRY_W-1:0] wr_data, ram_rdata;

    assign hit   = trig_ext | (trig_pc_en & (tr_pc == trig_pc)) | (trig_mw_en & tr_mem_we);
    assign store = tr_valid & ~arm & ((state_q == TR_PRE) | (state_q == TR_POST));

`ifdef MIPS_TRACE_TIMESTAMP_EN
    logic [31:0] stamp_q;

    // Free-running cycle stamp, restarted by reset and arm.
    always_ff @(posedge clk) begin
        if (reset || arm) stamp_q <= '0;
        else              stamp_q <= stamp_q + 32'd1;
    end

    assign wr_data = {1'b0, tr_pc, tr_instr, tr_rf_we, tr_rf_wa, tr_rf_wd,
                      tr_mem_we, tr_mem_addr, tr_mem_wd, stamp_q};
`else
    assign wr_data = {1'b0, tr_pc, tr_instr, tr_rf_we, tr_rf_wa, tr_rf_wd,
                      tr_mem_we, tr_mem_addr, tr_mem_wd};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= TR_IDLE;
        else       state_q <= state_d;
    end

    // Next state: arm restarts capture from any state; the last post-trigger
    // store closes the capture on the same edge.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = TR_PRE;
        end else begin
            case (state_q)
                TR_PRE:  if (tr_valid && hit)
                             state_d = (POST_TRIG == 0) ? TR_DONE : TR_POST;
                TR_POST: if (tr_valid && post_cnt_q == AW'(1))
                             state_d = TR_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Pointer, fill count and post-trigger countdown updates.
    always_comb begin
        wptr_d     = wptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        trig_pos_d = trig_pos_q;
        trig_calc  = '0;
        if (arm) begin
            wptr_d     = '0;
            count_d    = '0;
            post_cnt_d = '0;
        end else if (store) begin
            wptr_d  = wptr_q + AW'(1);
            count_d = (count_q == FULL) ? count_q : count_q + (AW+1)'(1);
            if (state_q == TR_PRE && hit) post_cnt_d = AW'(POST_TRIG);
            else if (state_q == TR_POST)  post_cnt_d = post_cnt_q - AW'(1);
        end
        if (state_d == TR_DONE && state_q != TR_DONE) begin
            trig_calc  = count_d - (AW+1)'(POST_TRIG + 1);
            trig_pos_d = trig_calc[AW-1:0];
        end
    end

    // Capture control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            trig_pos_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            trig_pos_q <= trig_pos_d;
        end
    end

    // Readout: once the buffer has wrapped, the oldest entry sits at wptr.
    assign rd_hit      = rd_en & (state_q == TR_DONE);
    assign rd_in_range = {1'b0, rd_idx} < count_q;
    assign rd_base     = (count_q == FULL) ? wptr_q : '0;
    assign rd_addr     = rd_base + rd_idx;

    // Read qualifiers; an out-of-range index returns zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_hit;
            rd_ok_q    <= rd_hit & rd_in_range;
        end
    end

    mips_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wptr_q),
        .wdata (wr_data),
        .re    (rd_hit),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_ok_q ? ram_rdata : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign trig_pos = trig_pos_q;
    assign done     = (state_q == TR_DONE);

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer with DEPTH=8, POST_TRIG=2.
module tb_mips_trace_buffer;
    import mips_trace_pkg::*;

    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 2;
    localparam int XLEN      = 32;
    localparam int AW        = 3;
    localparam int ENTRY_W   = entry_w(XLEN);
    localparam int BASE_W    = 5 * XLEN + 8;

    logic               clk = 1'b0;
    logic               reset, arm, trig_ext, trig_pc_en, trig_mw_en;
    logic [XLEN-1:0]    trig_pc;
    logic               tr_valid, tr_rf_we, tr_mem_we;
    logic [XLEN-1:0]    tr_pc, tr_instr, tr_rf_wd, tr_mem_addr, tr_mem_wd;
    logic [4:0]         tr_rf_wa;
    logic               rd_en;
    logic [AW-1:0]      rd_idx;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [1:0]         state;
    logic [AW:0]        count;
    logic [AW-1:0]      trig_pos;
    logic               done;

    int nvec = 0;
    int nerr = 0;

    logic              rv;
    logic [BASE_W-1:0] rdat;

    mips_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_ext(trig_ext),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_mw_en(trig_mw_en),
        .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_instr(tr_instr),
        .tr_rf_we(tr_rf_we), .tr_rf_wa(tr_rf_wa), .tr_rf_wd(tr_rf_wd),
        .tr_mem_we(tr_mem_we), .tr_mem_addr(tr_mem_addr), .tr_mem_wd(tr_mem_wd),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
        .state(state), .count(count), .trig_pos(trig_pos), .done(done)
    );

    always #5 clk = ~clk;

    // Expected entry for a sample driven by task send().
    function automatic logic [BASE_W-1:0] make_entry(input logic [31:0] pc, input logic mw,
                                                     input logic [31:0] ma, input logic [31:0] md);
        return {1'b0, pc, pc ^ 32'h2000_0000, pc[2], pc[6:2], pc + 32'd1, mw, ma, md};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drive_sample(input logic [31:0] pc, input logic mw,
                                input logic [31:0] ma, input logic [31:0] md);
        tr_valid    = 1'b1;
        tr_pc       = pc;
        tr_instr    = pc ^ 32'h2000_0000;
        tr_rf_we    = pc[2];
        tr_rf_wa    = pc[6:2];
        tr_rf_wd    = pc + 32'd1;
        tr_mem_we   = mw;
        tr_mem_addr = ma;
        tr_mem_wd   = md;
    endtask

    task automatic send(input logic [31:0] pc, input logic mw,
                        input logic [31:0] ma, input logic [31:0] md);
        drive_sample(pc, mw, ma, md);
        step();
        tr_valid  = 1'b0;
        tr_mem_we = 1'b0;
    endtask

    task automatic do_read(input int idx);
        rd_en  = 1'b1;
        rd_idx = AW'(idx);
        step();
        rd_en  = 1'b0;
        rv     = rd_valid;
        rdat   = rd_data[ENTRY_W-1:STAMP_W];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", state); end
        nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %0b want 0", done); end
        nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        reset = 1'b0;
        do_read(0);
        nvec++; if (rv !== 1'b0) begin nerr++; $display("FAIL idle_read_valid got %0b want 0", rv); end
    endtask

    task automatic test_pc_trigger();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h8;
        pulse_arm();
        nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL arm_state got %0d want 1", state); end
        for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b0, 32'h0, 32'h0);
        nvec++; if (state !== 2'd2) begin nerr++; $display("FAIL pc_post_state got %0d want 2", state); end
        send(32'h10, 1'b0, 32'h0, 32'h0);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL pc_done got %0b want 1", done); end
        nvec++; if (count !== 4'd5) begin nerr++; $display("FAIL pc_count got %0d want 5", count); end
        nvec++; if (trig_pos !== 3'd2) begin nerr++; $display("FAIL pc_trig_pos got %0d want 2", trig_pos); end
        for (int i = 0; i < 5; i++) begin
            do_read(i);
            nvec++;
            if (rv !== 1'b1 || rdat !== make_entry(32'(i * 4), 1'b0, 32'h0, 32'h0)) begin
                nerr++; $display("FAIL pc_read idx%0d got v=%0b %h want %h", i, rv, rdat,
                                 make_entry(32'(i * 4), 1'b0, 32'h0, 32'h0));
            end
        end
        do_read(6);
        nvec++; if (rv !== 1'b1 || rdat !== '0) begin nerr++; $display("FAIL pc_read_oob got v=%0b %h want v=1 0", rv, rdat); end
    endtask

    task automatic test_wrap();
        trig_pc = 32'h24;
        pulse_arm();
        for (int i = 0; i < 12; i++) send(32'(i * 4), 1'b0, 32'h0, 32'h0);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL wrap_done got %0b want 1", done); end
        nvec++; if (count !== 4'd8) begin nerr++; $display("FAIL wrap_count got %0d want 8", count); end
        nvec++; if (trig_pos !== 3'd5) begin nerr++; $display("FAIL wrap_trig_pos got %0d want 5", trig_pos); end
        do_read(0);
        nvec++; if (rdat !== make_entry(32'h10, 1'b0, 32'h0, 32'h0)) begin nerr++; $display("FAIL wrap_idx0 got %h", rdat); end
        do_read(5);
        nvec++; if (rdat !== make_entry(32'h24, 1'b0, 32'h0, 32'h0)) begin nerr++; $display("FAIL wrap_idx5 got %h", rdat); end
        do_read(7);
        nvec++; if (rdat !== make_entry(32'h2c, 1'b0, 32'h0, 32'h0)) begin nerr++; $display("FAIL wrap_idx7 got %h", rdat); end
    endtask

    task automatic test_memwrite_gaps();
        trig_pc_en = 1'b0;
        trig_mw_en = 1'b1;
        pulse_arm();
        send(32'h100, 1'b0, 32'h0, 32'h0);
        tr_mem_we = 1'b1;   // memwrite without a retiring instruction must not trigger
        step();
        tr_mem_we = 1'b0;
        step();
        send(32'h104, 1'b0, 32'h0, 32'h0);
        step();
        send(32'h108, 1'b1, 32'h54, 32'h7);
        step();
        send(32'h10c, 1'b0, 32'h0, 32'h0);
        step();
        step();
        send(32'h110, 1'b0, 32'h0, 32'h0);
        nvec++; if (count !== 4'd5 || done !== 1'b1) begin nerr++; $display("FAIL mw_count got %0d done %0b want 5 1", count, done); end
        nvec++; if (trig_pos !== 3'd2) begin nerr++; $display("FAIL mw_trig_pos got %0d want 2", trig_pos); end
        do_read(1);
        nvec++; if (rdat !== make_entry(32'h104, 1'b0, 32'h0, 32'h0)) begin nerr++; $display("FAIL mw_idx1 got %h", rdat); end
        do_read(2);
        nvec++; if (rdat !== make_entry(32'h108, 1'b1, 32'h54, 32'h7)) begin nerr++; $display("FAIL mw_idx2 got %h", rdat); end
        trig_mw_en = 1'b0;
    endtask

    task automatic test_arm_in_post();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h200;
        pulse_arm();
        send(32'h1fc, 1'b0, 32'h0, 32'h0);
        send(32'h200, 1'b0, 32'h0, 32'h0);
        nvec++; if (state !== 2'd2 || count !== 4'd2) begin nerr++; $display("FAIL rearm_pre got state %0d count %0d want 2 2", state, count); end
        arm = 1'b1;
        drive_sample(32'h300, 1'b0, 32'h0, 32'h0);
        step();
        arm = 1'b0;
        tr_valid = 1'b0;
        nvec++; if (state !== 2'd1 || count !== 4'd0) begin nerr++; $display("FAIL rearm_state got state %0d count %0d want 1 0", state, count); end
        send(32'h204, 1'b0, 32'h0, 32'h0);
        send(32'h200, 1'b0, 32'h0, 32'h0);
        send(32'h208, 1'b0, 32'h0, 32'h0);
        send(32'h20c, 1'b0, 32'h0, 32'h0);
        nvec++; if (count !== 4'd4 || trig_pos !== 3'd1) begin nerr++; $display("FAIL rearm_done got count %0d pos %0d want 4 1", count, trig_pos); end
        do_read(0);
        nvec++; if (rdat !== make_entry(32'h204, 1'b0, 32'h0, 32'h0)) begin nerr++; $display("FAIL rearm_idx0 got %h", rdat); end
        // reset coinciding with a read drops it
        reset  = 1'b1;
        rd_en  = 1'b1;
        rd_idx = 3'd0;
        step();
        reset = 1'b0;
        rd_en = 1'b0;
        nvec++; if (rd_valid !== 1'b0 || state !== 2'd0) begin nerr++; $display("FAIL reset_read got v=%0b state %0d want 0 0", rd_valid, state); end
    endtask

    task automatic test_reset_in_post();
        pulse_arm();
        send(32'h200, 1'b0, 32'h0, 32'h0);
        nvec++; if (state !== 2'd2) begin nerr++; $display("FAIL rst_post_pre got %0d want 2", state); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvec++; if (state !== 2'd0 || count !== 4'd0 || done !== 1'b0) begin
            nerr++; $display("FAIL rst_post got state %0d count %0d done %0b want 0 0 0", state, count, done);
        end
        pulse_arm();
        send(32'h200, 1'b0, 32'h0, 32'h0);
        send(32'h204, 1'b0, 32'h0, 32'h0);
        send(32'h208, 1'b0, 32'h0, 32'h0);
        nvec++; if (done !== 1'b1 || count !== 4'd3 || trig_pos !== 3'd0) begin
            nerr++; $display("FAIL rst_recap got done %0b count %0d pos %0d want 1 3 0", done, count, trig_pos);
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_idx = AW'(i);
            step();
            nvec++;
            if (i < 3) begin
                if (rd_valid !== 1'b1 || rd_data[ENTRY_W-1:STAMP_W] !== make_entry(32'(32'h200 + i * 4), 1'b0, 32'h0, 32'h0)) begin
                    nerr++; $display("FAIL b2b_idx%0d got v=%0b %h", i, rd_valid, rd_data[ENTRY_W-1:STAMP_W]);
                end
            end else if (rd_valid !== 1'b1 || rd_data !== '0) begin
                nerr++; $display("FAIL b2b_oob got v=%0b %h want v=1 0", rd_valid, rd_data);
            end
        end
        rd_en = 1'b0;
        step();
        nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL b2b_stop got %0b want 0", rd_valid); end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_ext = 1'b0; trig_pc_en = 1'b0; trig_pc = '0;
        trig_mw_en = 1'b0; tr_valid = 1'b0; tr_pc = '0; tr_instr = '0; tr_rf_we = 1'b0;
        tr_rf_wa = '0; tr_rf_wd = '0; tr_mem_we = 1'b0; tr_mem_addr = '0; tr_mem_wd = '0;
        rd_en = 1'b0; rd_idx = '0;
        test_reset();
        test_pc_trigger();
        test_wrap();
        test_memwrite_gaps();
        test_arm_in_post();
        test_reset_in_post();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
